// File: rtl/app_mem_responder_pkg.sv
// Shared definitions for the memory responder: default parameter values,
// interface field widths and the controller state encoding.
package app_mem_responder_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_INIT_CYCLES = 16;
  localparam int DEF_RD_LAT      = 3;

  localparam int APP_ADDR_W = 26;
  localparam int LEN_W      = 9;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_RDLAT,
    S_READ
  } state_t;

endpackage

// File: rtl/app_mem_ram.sv
// Byte-enabled synchronous single-port RAM, 2^ADDR_W x 32 bits.
// Ports:
//   clk, rst : clock, async active-high reset (read register only)
//   addr     : word address shared by read and write
//   wdata/be : write data and active-high byte enables, applied when we=1
//   re       : loads rdata with mem[addr] at the edge
//   rdata    : registered read data; holds its value while re=0
// Array contents are never reset so data survives a reset pulse.
module app_mem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  input  logic              we,
  input  logic              re,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/app_mem_responder.sv
// Memory-backed responder for an SDRAM-controller style application port.
// After an INIT_CYCLES power-up delay it accepts burst read/write requests
// and serves them from an internal 2^ADDR_W-word RAM.
// Ports:
//   clk, reset          : clock, async active-high reset
//   app_req/_addr/_len/_wr_n, app_req_ack : request handshake
//   app_wr_data, app_wr_en_n, app_wr_next_req, app_last_wr : write beats
//   app_rd_data, app_rd_valid, app_last_rd : read beats
//   sdr_init_done       : ready indication, high from end of init until reset
module app_mem_responder
  import app_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int RD_LAT      = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  app_req,
  input  logic [APP_ADDR_W-1:0] app_req_addr,
  input  logic [LEN_W-1:0]      app_req_len,
  input  logic                  app_req_wr_n,
  output logic                  app_req_ack,
  input  logic [DATA_W-1:0]     app_wr_data,
  input  logic [3:0]            app_wr_en_n,
  output logic                  app_wr_next_req,
  output logic                  app_last_wr,
  output logic [DATA_W-1:0]     app_rd_data,
  output logic                  app_rd_valid,
  output logic                  app_last_rd,
  output logic                  sdr_init_done
);

  state_t             state;
  logic [15:0]        init_cnt;
  logic [ADDR_W-1:0]  ptr;
  logic [LEN_W-1:0]   rem;      // beats not yet issued
  logic [3:0]         lat_cnt;
  logic               accept;
  logic               ram_re;
  logic               ram_we;

  // Only the low ADDR_W address bits select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^app_req_addr[APP_ADDR_W-1:ADDR_W];

  // The ack cycle itself is spent in IDLE for len=0, so a request still
  // held during its own ack cycle must not be accepted a second time.
  assign accept = (state == S_IDLE) && app_req && !app_req_ack;

  // RAM read is issued one edge ahead of the valid beat it produces.
  assign ram_re = ((state == S_RDLAT) && (lat_cnt == 4'(RD_LAT - 1))) ||
                  ((state == S_READ)  && (rem != '0));
  assign ram_we = app_wr_next_req;

  app_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (reset),
    .addr  (ptr),
    .wdata (app_wr_data),
    .be    (~app_wr_en_n),
    .we    (ram_we),
    .re    (ram_re),
    .rdata (app_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_INIT;
      init_cnt        <= '0;
      ptr             <= '0;
      rem             <= '0;
      lat_cnt         <= '0;
      app_req_ack     <= 1'b0;
      app_wr_next_req <= 1'b0;
      app_last_wr     <= 1'b0;
      app_rd_valid    <= 1'b0;
      app_last_rd     <= 1'b0;
      sdr_init_done   <= 1'b0;
    end else begin
      app_req_ack <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_cnt == 16'(INIT_CYCLES - 1)) begin
            sdr_init_done <= 1'b1;
            state         <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + 16'd1;
          end
        end

        S_IDLE: begin
          if (accept) begin
            app_req_ack <= 1'b1;
            ptr         <= app_req_addr[ADDR_W-1:0];
            rem         <= app_req_len;
            lat_cnt     <= '0;
            if (app_req_len != '0)
              state <= app_req_wr_n ? S_RDLAT : S_WRITE;
          end
        end

        S_WRITE: begin
          if (!app_wr_next_req) begin
            // Ack cycle: raise the first beat for the following cycle.
            app_wr_next_req <= 1'b1;
            app_last_wr     <= (rem == LEN_W'(1));
          end else begin
            ptr <= ptr + 1'b1;
            rem <= rem - 1'b1;
            if (rem == LEN_W'(1)) begin
              app_wr_next_req <= 1'b0;
              app_last_wr     <= 1'b0;
              state           <= S_IDLE;
            end else begin
              app_last_wr <= (rem == LEN_W'(2));
            end
          end
        end

        S_RDLAT: begin
          if (ram_re) begin
            ptr          <= ptr + 1'b1;
            rem          <= rem - 1'b1;
            app_rd_valid <= 1'b1;
            app_last_rd  <= (rem == LEN_W'(1));
            state        <= S_READ;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end

        S_READ: begin
          if (ram_re) begin
            ptr          <= ptr + 1'b1;
            rem          <= rem - 1'b1;
            app_rd_valid <= 1'b1;
            app_last_rd  <= (rem == LEN_W'(1));
          end else begin
            // Final beat is on the outputs now; return for the next request.
            app_rd_valid <= 1'b0;
            app_last_rd  <= 1'b0;
            state        <= S_IDLE;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_app_mem_responder.sv
// Directed bench for app_mem_responder with a reference memory model and a
// queue of expected read beats.
module tb_app_mem_responder;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        app_req = 1'b0;
  logic [25:0] app_req_addr = '0;
  logic [8:0]  app_req_len = '0;
  logic        app_req_wr_n = 1'b1;
  logic [31:0] app_wr_data = '0;
  logic [3:0]  app_wr_en_n = 4'hF;
  logic        app_req_ack;
  logic        app_wr_next_req;
  logic        app_last_wr;
  logic [31:0] app_rd_data;
  logic        app_rd_valid;
  logic        app_last_rd;
  logic        sdr_init_done;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [256];
  logic [31:0] exp_q [$];

  app_mem_responder #(.ADDR_W(8), .INIT_CYCLES(16), .RD_LAT(RD_LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .app_req         (app_req),
    .app_req_addr    (app_req_addr),
    .app_req_len     (app_req_len),
    .app_req_wr_n    (app_req_wr_n),
    .app_req_ack     (app_req_ack),
    .app_wr_data     (app_wr_data),
    .app_wr_en_n     (app_wr_en_n),
    .app_wr_next_req (app_wr_next_req),
    .app_last_wr     (app_last_wr),
    .app_rd_data     (app_rd_data),
    .app_rd_valid    (app_rd_valid),
    .app_last_rd     (app_last_rd),
    .sdr_init_done   (sdr_init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns how many negedges passed until ack was seen.
  task automatic request(input logic wr_n, input logic [25:0] addr, input logic [8:0] len,
                         output int waited);
    app_req = 1'b1; app_req_wr_n = wr_n; app_req_addr = addr; app_req_len = len;
    waited = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (app_req_ack) break;
      if (waited > 60) begin chk("ack_timeout", 32'd0, 32'd1); break; end
    end
    app_req = 1'b0;
  endtask

  task automatic do_write(input logic [25:0] addr, input logic [8:0] len, input logic [31:0] base,
                          input logic [3:0] en_n, input bit incr, output int waited);
    logic [7:0]  a;
    logic [31:0] d;
    request(1'b0, addr, len, waited);
    for (int k = 0; k < int'(len); k++) begin
      @(negedge clk);
      chk("wr_next_req", 32'(app_wr_next_req), 32'd1);
      chk("wr_last", 32'(app_last_wr), 32'(k == int'(len) - 1));
      if (k == 0) chk("ack_pulse", 32'(app_req_ack), 32'd0);
      d = base + (incr ? 32'(k) : 32'd0);
      app_wr_data = d; app_wr_en_n = en_n;
      a = 8'(int'(addr[7:0]) + k);
      for (int i = 0; i < 4; i++)
        if (!en_n[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end
    @(negedge clk);
    chk("wr_idle_next_req", 32'(app_wr_next_req), 32'd0);
    if (len == 9'd0) chk("len0_ack_pulse", 32'(app_req_ack), 32'd0);
    app_wr_en_n = 4'hF;
  endtask

  // abort_beat >= 0 asserts reset right after that beat has been checked.
  task automatic do_read(input logic [25:0] addr, input logic [8:0] len, input int abort_beat,
                         output int waited);
    logic [31:0] e;
    logic [31:0] last_e;
    last_e = '0;
    for (int k = 0; k < int'(len); k++) exp_q.push_back(model[8'(int'(addr[7:0]) + k)]);
    request(1'b1, addr, len, waited);
    for (int c = 1; c < RD_LAT; c++) begin
      @(negedge clk);
      chk("rd_latency_quiet", 32'(app_rd_valid), 32'd0);
    end
    for (int k = 0; k < int'(len); k++) begin
      @(negedge clk);
      chk("rd_valid", 32'(app_rd_valid), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("rd_data", app_rd_data, e);
      chk("rd_last", 32'(app_last_rd), 32'(k == int'(len) - 1));
      last_e = e;
      if (k == abort_beat) begin
        reset = 1'b1;
        #1;
        chk("abort_valid", 32'(app_rd_valid), 32'd0);
        chk("abort_rd_data", app_rd_data, 32'd0);
        chk("abort_init_done", 32'(sdr_init_done), 32'd0);
        exp_q.delete();
        return;
      end
    end
    @(negedge clk);
    chk("rd_end_valid", 32'(app_rd_valid), 32'd0);
    chk("rd_data_hold", app_rd_data, last_e);
  endtask

  task automatic release_and_init(output int n);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (sdr_init_done || n > 40) break;
    end
  endtask

  initial begin
    int w;
    int n;
    // Request held through reset: a len=0 read, so nothing follows its ack.
    app_req = 1'b1; app_req_wr_n = 1'b1; app_req_len = 9'd0; app_req_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(app_req_ack), 32'd0);
    chk("rst_next_req", 32'(app_wr_next_req), 32'd0);
    chk("rst_last_wr", 32'(app_last_wr), 32'd0);
    chk("rst_rd_valid", 32'(app_rd_valid), 32'd0);
    chk("rst_last_rd", 32'(app_last_rd), 32'd0);
    chk("rst_init_done", 32'(sdr_init_done), 32'd0);
    chk("rst_rd_data", app_rd_data, 32'd0);

    release_and_init(n);
    chk("init_cycles", 32'(n), 32'd16);
    chk("init_no_ack", 32'(app_req_ack), 32'd0);
    @(negedge clk);
    chk("held_req_ack", 32'(app_req_ack), 32'd1);
    app_req = 1'b0;
    @(negedge clk);
    chk("held_ack_pulse", 32'(app_req_ack), 32'd0);
    chk("held_no_valid", 32'(app_rd_valid), 32'd0);

    // Burst of 5 then back-to-back read of the same words.
    do_write(26'h100000, 9'd5, 32'd10, 4'h0, 1'b1, w);
    do_read(26'h100000, 9'd5, -1, w);
    chk("b2b_ack_wait", 32'(w), 32'd1);

    // Partial byte-lane write.
    do_write(26'h10, 9'd1, 32'hAABBCCDD, 4'h0, 1'b0, w);
    do_write(26'h10, 9'd1, 32'h11223344, 4'b1010, 1'b0, w);
    do_read(26'h10, 9'd1, -1, w);

    // Address wrap from 0xFE.
    do_write(26'hFE, 9'd4, 32'd1, 4'h0, 1'b1, w);
    do_read(26'h0, 9'd2, -1, w);

    // Zero-length write followed immediately by a read.
    do_write(26'h20, 9'd0, 32'h0, 4'h0, 1'b0, w);
    do_read(26'h10, 9'd1, -1, w);
    chk("len0_next_ack_wait", 32'(w), 32'd1);

    // Reset during read beat 2 of 8; contents must survive.
    do_write(26'h40, 9'd8, $urandom, 4'h0, 1'b1, w);
    do_read(26'h40, 9'd8, 1, w);
    release_and_init(n);
    chk("reinit_cycles", 32'(n), 32'd16);
    @(negedge clk);
    do_read(26'h40, 9'd8, -1, w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
